// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared constants, command encodings and enums for the console writer
package console_pkg;

  localparam int COLS    = 42;
  localparam int ROWS    = 22;
  localparam int A_WIDTH = 13;
  localparam int CELLS   = COLS * ROWS;

  localparam logic [7:0] BLANK = 8'h20;

  // Command encodings shared with the character-memory controller
  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_WRITE1 = 3'b001;
  localparam logic [2:0] CMD_WRITE2 = 3'b010;

  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;

  typedef enum logic [2:0] {
    IDLE, DECODE, ISSUE, WAIT_ACK, WAIT_REL, CLEAR
  } state_e;

  typedef enum logic [2:0] {
    CUR_NONE, CUR_INC, CUR_NL, CUR_CR, CUR_BS, CUR_HOME
  } cur_op_e;

endpackage

// File: rtl/console_writer_if.sv
// rtl/console_writer_if.sv - byte stream in, character-memory command bus out
interface console_writer_if;
  import console_pkg::*;

  logic               ch_valid;
  logic [7:0]         ch_data;
  logic               ch_ready;
  logic [2:0]         cmd;
  logic [A_WIDTH-1:0] addr;
  logic [7:0]         din1;
  logic [7:0]         din2;
  logic               op_cplt;

  modport master (
    input  ch_valid, ch_data, op_cplt,
    output ch_ready, cmd, addr, din1, din2
  );

  modport slave (
    output ch_valid, ch_data, op_cplt,
    input  ch_ready, cmd, addr, din1, din2
  );

endinterface

// File: rtl/cursor_ctrl.sv
// rtl/cursor_ctrl.sv - text cursor with column, row and linear address kept in step
module cursor_ctrl
  import console_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  cur_op_e            op_i,
  output logic [5:0]         col_o,
  output logic [4:0]         row_o,
  output logic [A_WIDTH-1:0] addr_nxt_o
);

  logic [5:0]         col_q, col_d;
  logic [4:0]         row_q, row_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic               last_col, last_row;

  assign last_col = (col_q == 6'(COLS - 1));
  assign last_row = (row_q == 5'(ROWS - 1));

  // Address moves by +/-1 or by a row stride, so no multiply is ever needed
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    case (op_i)
      CUR_INC: begin
        if (last_col) begin
          col_d  = 6'd0;
          row_d  = last_row ? 5'd0 : row_q + 5'd1;
          addr_d = last_row ? '0 : addr_q + 1'b1;
        end else begin
          col_d  = col_q + 6'd1;
          addr_d = addr_q + 1'b1;
        end
      end
      CUR_NL: begin
        col_d  = 6'd0;
        row_d  = last_row ? 5'd0 : row_q + 5'd1;
        addr_d = last_row ? '0 : addr_q - A_WIDTH'(col_q) + A_WIDTH'(COLS);
      end
      CUR_CR: begin
        col_d  = 6'd0;
        addr_d = addr_q - A_WIDTH'(col_q);
      end
      CUR_BS: begin
        if (col_q != 6'd0) begin
          col_d  = col_q - 6'd1;
          addr_d = addr_q - 1'b1;
        end else if (row_q != 5'd0) begin
          col_d  = 6'(COLS - 1);
          row_d  = row_q - 5'd1;
          addr_d = addr_q - 1'b1;
        end
      end
      CUR_HOME: begin
        col_d  = 6'd0;
        row_d  = 5'd0;
        addr_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= 6'd0;
      row_q  <= 5'd0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign addr_nxt_o = addr_d;

endmodule

// File: rtl/console_writer.sv
// rtl/console_writer.sv - byte stream to character-memory writer with 4-phase handshake
// Optional: CONSOLE_FAST_CLEAR_EN clears the screen with WRITE2 pairs at even addresses.
module console_writer
  import console_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  console_writer_if.master        bus,
  output logic [5:0]              cur_col,
  output logic [4:0]              cur_row,
  output logic                    busy
);

`ifdef CONSOLE_FAST_CLEAR_EN
  localparam logic [2:0]         CLR_CMD  = CMD_WRITE2;
  localparam logic [7:0]         CLR_DIN2 = BLANK;
  localparam logic [A_WIDTH-1:0] CLR_STEP = A_WIDTH'(2);
  localparam logic [A_WIDTH-1:0] CLR_LAST = A_WIDTH'(CELLS - 2);
`else
  localparam logic [2:0]         CLR_CMD  = CMD_WRITE1;
  localparam logic [7:0]         CLR_DIN2 = 8'h00;
  localparam logic [A_WIDTH-1:0] CLR_STEP = A_WIDTH'(1);
  localparam logic [A_WIDTH-1:0] CLR_LAST = A_WIDTH'(CELLS - 1);
`endif

  state_e             state_q, state_d;
  logic [7:0]         char_q, char_d;
  logic [2:0]         cmd_q, cmd_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]         din1_q, din1_d, din2_q, din2_d;
  logic [A_WIDTH-1:0] clr_q, clr_d;
  logic               clr_mode_q, clr_mode_d;
  logic               print_q, print_d;
  logic               ready_q, ready_d;
  cur_op_e            cur_op;
  logic [5:0]         col;
  logic [4:0]         row;
  logic [A_WIDTH-1:0] cur_addr_nxt;

  cursor_ctrl u_cursor (
    .clk        (clk),
    .rst        (rst),
    .op_i       (cur_op),
    .col_o      (col),
    .row_o      (row),
    .addr_nxt_o (cur_addr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      char_q     <= 8'h00;
      cmd_q      <= CMD_NOP;
      addr_q     <= '0;
      din1_q     <= 8'h00;
      din2_q     <= 8'h00;
      clr_q      <= '0;
      clr_mode_q <= 1'b0;
      print_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      char_q     <= char_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      din1_q     <= din1_d;
      din2_q     <= din2_d;
      clr_q      <= clr_d;
      clr_mode_q <= clr_mode_d;
      print_q    <= print_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    char_d     = char_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    din1_d     = din1_q;
    din2_d     = din2_q;
    clr_d      = clr_q;
    clr_mode_d = clr_mode_q;
    print_d    = print_q;
    cur_op     = CUR_NONE;
    case (state_q)
      IDLE: begin
        if (bus.ch_valid && ready_q) begin
          char_d  = bus.ch_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d    = IDLE;
        clr_mode_d = 1'b0;
        if (char_q >= 8'h20 && char_q <= 8'h7E) begin
          cmd_d   = CMD_WRITE1;
          addr_d  = cur_addr_nxt;
          din1_d  = char_q;
          din2_d  = 8'h00;
          print_d = 1'b1;
          state_d = ISSUE;
        end else if (char_q == LF) begin
          cur_op = CUR_NL;
        end else if (char_q == CR) begin
          cur_op = CUR_CR;
        end else if (char_q == BS) begin
          // The blank lands on the post-backspace position, taken from the cursor's next address
          cur_op  = CUR_BS;
          cmd_d   = CMD_WRITE1;
          addr_d  = cur_addr_nxt;
          din1_d  = BLANK;
          din2_d  = 8'h00;
          print_d = 1'b0;
          state_d = ISSUE;
        end else if (char_q == FF) begin
          clr_d      = '0;
          clr_mode_d = 1'b1;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        cmd_d   = CLR_CMD;
        addr_d  = clr_q;
        din1_d  = BLANK;
        din2_d  = CLR_DIN2;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.op_cplt) begin
          cmd_d   = CMD_NOP;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!bus.op_cplt) begin
          if (clr_mode_q) begin
            if (clr_q == CLR_LAST) begin
              cur_op     = CUR_HOME;
              clr_mode_d = 1'b0;
              state_d    = IDLE;
            end else begin
              clr_d   = clr_q + CLR_STEP;
              state_d = CLEAR;
            end
          end else begin
            if (print_q) cur_op = CUR_INC;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_comb begin
    bus.ch_ready = ready_q;
    bus.cmd      = cmd_q;
    bus.addr     = addr_q;
    bus.din1     = din1_q;
    bus.din2     = din2_q;
    busy         = (state_q != IDLE);
    cur_col      = col;
    cur_row      = row;
  end

endmodule

// File: tb/tb_console_writer.sv
// tb/tb_console_writer.sv - directed bench for console_writer with a 4-phase responder
// Expected clear counts follow CONSOLE_FAST_CLEAR_EN.
module tb_console_writer;
  import console_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;

  console_writer_if bif ();

  console_writer dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif),
    .cur_col (cur_col),
    .cur_row (cur_row),
    .busy    (busy)
  );

  always #5 clk = ~clk;

`ifdef CONSOLE_FAST_CLEAR_EN
  localparam int EXP_STEP = 2, EXP_W1 = 0, EXP_W2 = 462, EXP_LAST = 922;
`else
  localparam int EXP_STEP = 1, EXP_W1 = 924, EXP_W2 = 0, EXP_LAST = 923;
`endif

  int errs = 0, checks = 0;
  int ack_dly = 3, hold = 1;
  int ncmd, n_w1, n_w2, last_cmd, last_addr, last_din1, last_din2;
  int late_drop = 0, viol = 0, rdy_viol = 0, stable_err = 0, clr_err = 0;
  bit clr_chk = 0;
  int clr_exp = 0;
  int phase = 0, cnt = 0;
  bit seen0 = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    ncmd = 0; n_w1 = 0; n_w2 = 0;
    last_cmd = -1; last_addr = -1; last_din1 = -1; last_din2 = -1;
  endtask

  // Responder: ack ack_dly cycles after a command appears, hold op_cplt for hold cycles
  initial begin
    bif.op_cplt = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bif.op_cplt = 1'b0; phase = 0; cnt = 0;
      end else begin
        case (phase)
          0: if (bif.cmd != CMD_NOP) begin
               ncmd++;
               last_cmd = bif.cmd; last_addr = bif.addr;
               last_din1 = bif.din1; last_din2 = bif.din2;
               if (bif.cmd == CMD_WRITE1) n_w1++;
               if (bif.cmd == CMD_WRITE2) n_w2++;
               if (clr_chk) begin
                 if (int'(bif.addr) != clr_exp || bif.din1 != BLANK ||
                     int'(bif.din2) != (EXP_STEP == 2 ? 32 : 0)) clr_err++;
                 clr_exp += EXP_STEP;
               end
               cnt = 0; phase = 1;
             end
          1: begin
               cnt++;
               if (int'(bif.cmd) != last_cmd || int'(bif.addr) != last_addr ||
                   int'(bif.din1) != last_din1) stable_err++;
               if (cnt >= ack_dly) begin
                 bif.op_cplt = 1'b1; cnt = 0; seen0 = 0; phase = 2;
               end
             end
          default: begin
               cnt++;
               if (cnt == 1 && bif.cmd != CMD_NOP) late_drop++;
               if (bif.cmd == CMD_NOP) seen0 = 1;
               else if (seen0) viol++;
               if (bif.ch_ready) rdy_viol++;
               if (cnt >= hold) begin
                 bif.op_cplt = 1'b0; phase = 0;
               end
             end
        endcase
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bif.ch_valid = 1'b1;
    bif.ch_data  = b;
    while (!bif.ch_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bif.ch_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy || !bif.ch_ready) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check(tag, 0, 1);
  endtask

  initial begin
    int n, rdy_bad;
    rst = 1'b1;
    bif.ch_valid = 1'b0;
    bif.ch_data  = 8'h00;
    clear_counts();
    repeat (3) @(negedge clk);
    check("rst_cmd", bif.cmd, 0);
    check("rst_addr", bif.addr, 0);
    check("rst_din1", bif.din1, 0);
    check("rst_din2", bif.din2, 0);
    check("rst_col", cur_col, 0);
    check("rst_row", cur_row, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", bif.ch_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bif.ch_ready, 1);

    // 'A' at 0,0 with 3-cycle ack
    clear_counts();
    send_byte(8'h41);
    @(negedge clk);
    check("lat_decode_cmd", bif.cmd, 0);
    @(negedge clk);
    check("lat_issue_cmd", bif.cmd, 1);
    wait_idle("idle_A");
    check("A_ncmd", ncmd, 1);
    check("A_cmd", last_cmd, 1);
    check("A_addr", last_addr, 0);
    check("A_din1", last_din1, 65);
    check("A_din2", last_din2, 0);
    check("A_col", cur_col, 1);
    check("A_row", cur_row, 0);
    check("A_late_drop", late_drop, 0);

    // Fill to column 41, then 'Z' wraps to next row
    for (int i = 0; i < 40; i++) begin
      send_byte(8'h62);
      wait_idle("idle_fill");
    end
    check("fill_col", cur_col, 41);
    clear_counts();
    send_byte(8'h5A);
    wait_idle("idle_Z");
    check("Z_addr", last_addr, 41);
    check("Z_din1", last_din1, 90);
    check("Z_col", cur_col, 0);
    check("Z_row", cur_row, 1);

    // LF to row 21, then LF wraps to row 0 with no command
    for (int i = 0; i < 20; i++) begin
      send_byte(LF);
      wait_idle("idle_lf");
    end
    check("lf_row21", cur_row, 21);
    clear_counts();
    send_byte(LF);
    wait_idle("idle_lfwrap");
    check("lfwrap_row", cur_row, 0);
    check("lfwrap_col", cur_col, 0);
    check("lfwrap_ncmd", ncmd, 0);

    // BS at 0,0 stays and blanks addr 0
    clear_counts();
    send_byte(BS);
    wait_idle("idle_bs0");
    check("bs0_ncmd", ncmd, 1);
    check("bs0_addr", last_addr, 0);
    check("bs0_din1", last_din1, 32);
    check("bs0_col", cur_col, 0);
    check("bs0_row", cur_row, 0);

    // BS at 0,1 goes to 41,0 and blanks addr 41
    send_byte(LF);
    wait_idle("idle_lf2");
    clear_counts();
    send_byte(BS);
    wait_idle("idle_bs1");
    check("bs1_addr", last_addr, 41);
    check("bs1_din1", last_din1, 32);
    check("bs1_col", cur_col, 41);
    check("bs1_row", cur_row, 0);

    // op_cplt held 5 cycles with a second byte queued behind it
    hold = 5;
    clear_counts();
    send_byte(8'h71);
    send_byte(8'h72);
    wait_idle("idle_hold");
    check("hold_ncmd", ncmd, 2);
    check("hold_addr", last_addr, 42);
    check("hold_din1", last_din1, 114);
    check("hold_col", cur_col, 1);
    check("hold_row", cur_row, 1);
    check("hold_viol", viol, 0);
    check("hold_ready_low", rdy_viol, 0);
    check("hold_late_drop", late_drop, 0);
    check("cmd_stable", stable_err, 0);
    hold = 1;

    // Form feed clears the whole grid
    ack_dly = 1;
    clear_counts();
    clr_exp = 0;
    clr_chk = 1;
    send_byte(FF);
    n = 0;
    rdy_bad = 0;
    while (busy && n < 20000) begin
      if (bif.ch_ready) rdy_bad++;
      @(negedge clk);
      n++;
    end
    clr_chk = 0;
    check("clr_timeout", int'(n < 20000), 1);
    check("clr_ncmd", ncmd, EXP_W1 + EXP_W2);
    check("clr_w1", n_w1, EXP_W1);
    check("clr_w2", n_w2, EXP_W2);
    check("clr_seq", clr_err, 0);
    check("clr_last", last_addr, EXP_LAST);
    check("clr_ready_low", rdy_bad, 0);
    check("clr_col", cur_col, 0);
    check("clr_row", cur_row, 0);
    wait_idle("idle_clr");
    check("clr_ready_after", bif.ch_ready, 1);

    // CR and dropped bytes
    ack_dly = 3;
    clear_counts();
    send_byte(8'h78);
    wait_idle("idle_x");
    send_byte(CR);
    wait_idle("idle_cr");
    check("cr_col", cur_col, 0);
    check("cr_row", cur_row, 0);
    send_byte(8'h01);
    wait_idle("idle_drop1");
    send_byte(8'h7F);
    wait_idle("idle_drop2");
    check("drop_ncmd", ncmd, 1);
    check("drop_col", cur_col, 0);

    // Reset during WAIT_ACK
    send_byte(8'h6B);
    wait_idle("idle_k");
    ack_dly = 30;
    send_byte(8'h6D);
    repeat (3) @(negedge clk);
    check("prerst_cmd", bif.cmd, 1);
    check("prerst_col", cur_col, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cmd", bif.cmd, 0);
    check("midrst_col", cur_col, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    ack_dly = 3;
    wait_idle("idle_postrst");
    clear_counts();
    send_byte(8'h6E);
    wait_idle("idle_n");
    check("postrst_ncmd", ncmd, 1);
    check("postrst_addr", last_addr, 0);
    check("postrst_din1", last_din1, 110);
    check("postrst_col", cur_col, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
